operand_latch: RTL and testbench
================================

OPERAND_LATCH -- requirements
Module: operand_latch

Interface
REQ-001 Parameter BIT_LEN, default 1: bit width of the operand bus and of outputs a and b.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 clear  input  1  synchronous flush; discards any partially or fully assembled pair.
REQ-005 in_data  input  BIT_LEN  operand word from upstream; first word of a pair is a, second is b.
REQ-006 in_valid  input  1  upstream asserts when in_data is valid.
REQ-007 in_ready  output  1  block accepts in_data this cycle.
REQ-008 a  output  BIT_LEN  first operand, held stable while out_valid=1; feeds the downstream gate input a.
REQ-009 b  output  BIT_LEN  second operand, held stable while out_valid=1; feeds the downstream gate input b.
REQ-010 out_valid  output  1  a/b form a complete pair.
REQ-011 out_ready  input  1  downstream consumes the pair this cycle.
REQ-012 pair_cnt  output  16  count of completed handoffs; present only when OPERAND_LATCH_CNT_EN is defined.

Function
REQ-013 An input transfer shall occur on the cycle in which in_valid=1 and in_ready=1; an output transfer on the cycle in which out_valid=1 and out_ready=1.
REQ-014 FSM states shall be EMPTY, HAVE_A and FULL.
REQ-015 EMPTY: in_ready=1, out_valid=0; an input transfer loads a from in_data and moves to HAVE_A.
REQ-016 HAVE_A: in_ready=1, out_valid=0; an input transfer loads b from in_data and moves to FULL.
REQ-017 FULL: out_valid=1, in_ready=out_ready (combinational).
REQ-018 FULL with an output transfer and no input transfer shall move to EMPTY.
REQ-019 FULL with simultaneous output and input transfers shall load a from in_data and move to HAVE_A, with no bubble.
REQ-020 a shall change only on a load in EMPTY or in a REQ-019 transfer; b shall change only on a load in HAVE_A; neither shall change at any other time.
REQ-021 Latency from the input transfer of b to out_valid=1 shall be exactly one cycle.
REQ-022 clear=1 shall force the state to EMPTY on the next edge, override any simultaneous transfer, and leave a and b unchanged.
REQ-023 While clear=1, in_ready shall be 0. out_valid shall follow the current state unaffected by clear, so an output transfer can still complete that cycle.
REQ-024 in_valid=0 or out_ready=0 shall hold the current state indefinitely.

Reset
REQ-025 rst=1 shall set state=EMPTY, a=0, b=0 and pair_cnt=0 on the next edge, overriding clear and all transfers, including any transfer in progress.
REQ-026 After reset, out_valid=0 and in_ready=1 from the first cycle with rst=0.

Configuration
REQ-027 With macro OPERAND_LATCH_CNT_EN defined, the block shall provide port pair_cnt.
REQ-028 pair_cnt shall increment by 1 on each output transfer and wrap from 16'hFFFF to 0.
REQ-029 Without OPERAND_LATCH_CNT_EN, the block shall have no pair_cnt port and no counter logic.

Structure
REQ-030 The FSM state enum typedef (EMPTY, HAVE_A, FULL) and the 16-bit counter width constant shall live in package operand_latch_pkg.
REQ-031 The a and b holding registers shall each be an instance of one sub-module, reg_en: a BIT_LEN-wide register with synchronous active-high reset and load enable.

Verification
REQ-032 BIT_LEN=4; push 4'hA then 4'h5 with out_ready=0 -> out_valid=1 one cycle after the second transfer; a=4'hA, b=4'h5, held stable for 10 stalled cycles.
REQ-033 In FULL (a=3, b=6): assert out_ready=1 and in_valid=1 with in_data=9 in the same cycle -> next state HAVE_A, a=9, out_valid=0, in_ready=1.
REQ-034 In HAVE_A: assert clear together with in_valid=1 -> state EMPTY, b unchanged, in_ready=0 during the clear cycle; the next word loads a.
REQ-035 Assert rst in FULL together with out_ready=1 -> a=0, b=0, out_valid=0, pair_cnt=0 after the edge.
REQ-036 With OPERAND_LATCH_CNT_EN: preload the count via 65535 handoffs, then complete one more -> pair_cnt reads 0.
REQ-037 Random in_valid/out_ready for 10k cycles -> pair order preserved (compared against a scoreboard) and no transfer lost or duplicated.

Source files
------------

// File: rtl/operand_latch_pkg.sv
// Shared types and constants for the operand_latch block.
package operand_latch_pkg;

    // Pair assembly progress: nothing held, first operand held, full pair held.
    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        HAVE_A = 2'd1,
        FULL   = 2'd2
    } state_t;

    // Width of the optional completed-handoff counter.
    localparam int CNT_W = 16;

endpackage

// File: rtl/operand_latch_reg_en.sv
// reg_en: WIDTH-bit holding register with synchronous active-high reset
// and load enable. Used for both operand registers of operand_latch.
module reg_en #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    // Load new data only when enabled, otherwise hold.
    always_comb begin
        q_d = en ? d : q_q;
    end

    // Storage; reset clears to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/operand_latch.sv
// operand_latch: assembles two consecutive upstream words into an (a, b)
// operand pair and presents it to a downstream gate with valid/ready
// handshakes on both sides. A consumed pair can be replaced by a new first
// operand in the same cycle, so the stream runs without bubbles.
// Optional feature: define OPERAND_LATCH_CNT_EN to add the 16-bit pair_cnt
// output counting completed output handoffs.
module operand_latch
    import operand_latch_pkg::*;
#(
    parameter int BIT_LEN = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic [BIT_LEN-1:0] in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [BIT_LEN-1:0] a,
    output logic [BIT_LEN-1:0] b,
    output logic               out_valid,
`ifdef OPERAND_LATCH_CNT_EN
    output logic [CNT_W-1:0]   pair_cnt,
`endif
    input  logic               out_ready
);

    state_t state_q;
    state_t state_d;
    logic   in_xfer;
    logic   out_xfer;
    logic   load_a;
    logic   load_b;

    // Handshake decode. out_valid is a pure state decode so a pending pair can
    // still be taken during a flush; the input side is closed while clearing.
    always_comb begin
        out_valid = (state_q == FULL);
        if (clear) begin
            in_ready = 1'b0;
        end else if (state_q == FULL) begin
            in_ready = out_ready;
        end else begin
            in_ready = 1'b1;
        end
        in_xfer  = in_valid && in_ready;
        out_xfer = out_valid && out_ready;
        // In FULL an input transfer implies an output transfer (in_ready
        // follows out_ready), so the incoming word always starts a new pair.
        load_a   = in_xfer && ((state_q == EMPTY) || (state_q == FULL));
        load_b   = in_xfer && (state_q == HAVE_A);
    end

    // Next-state logic; clear wins over any handshake.
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY:   if (in_xfer) state_d = HAVE_A;
                HAVE_A:  if (in_xfer) state_d = FULL;
                FULL: begin
                    if (out_xfer) begin
                        state_d = in_xfer ? HAVE_A : EMPTY;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    reg_en #(.WIDTH(BIT_LEN)) u_reg_a (
        .clk (clk),
        .rst (rst),
        .en  (load_a),
        .d   (in_data),
        .q   (a)
    );

    reg_en #(.WIDTH(BIT_LEN)) u_reg_b (
        .clk (clk),
        .rst (rst),
        .en  (load_b),
        .d   (in_data),
        .q   (b)
    );

`ifdef OPERAND_LATCH_CNT_EN
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Count every output handoff, wrapping naturally at the counter width.
    always_comb begin
        cnt_d = out_xfer ? cnt_q + CNT_W'(1) : cnt_q;
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign pair_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_operand_latch.sv
// Self-checking bench for operand_latch (BIT_LEN=4). Define
// OPERAND_LATCH_CNT_EN to also exercise pair_cnt and its wrap.
module tb_operand_latch;
    import operand_latch_pkg::*;

    logic       clk;
    logic       rst;
    logic       clear;
    logic [3:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] a;
    logic [3:0] b;
    logic       out_valid;
    logic       out_ready;
`ifdef OPERAND_LATCH_CNT_EN
    logic [CNT_W-1:0] pair_cnt;
`endif

    int checks;
    int failures;
    int exp_cnt;

    operand_latch #(.BIT_LEN(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
`ifdef OPERAND_LATCH_CNT_EN
        .pair_cnt  (pair_cnt),
`endif
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock edge; inputs are changed and outputs observed 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = 4'h0;
        tick(); tick();
        rst = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (a !== 4'h0 || b !== 4'h0) begin failures++; $display("FAIL reset_ab got=%h/%h exp=0/0", a, b); end
`ifdef OPERAND_LATCH_CNT_EN
        checks++; if (pair_cnt !== 16'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", pair_cnt); end
`endif
        exp_cnt = 0;
    endtask

    task automatic test_hold();
        in_valid = 1'b1; in_data = 4'hA; out_ready = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0 || a !== 4'hA) begin failures++; $display("FAIL hold_first got ov=%b a=%h exp ov=0 a=a", out_valid, a); end
        in_data = 4'h5;
        tick();
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL hold_latency got=%b exp=1", out_valid); end
        in_data = 4'hF;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (a !== 4'hA || b !== 4'h5 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                failures++;
                $display("FAIL hold_stall%0d got a=%h b=%h ov=%b ir=%b exp a=a b=5 ov=1 ir=0", i, a, b, out_valid, in_ready);
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL hold_ready_follow got=%b exp=1", in_ready); end
        tick();
        exp_cnt++;
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL hold_drain got ov=%b ir=%b exp ov=0 ir=1", out_valid, in_ready); end
`ifdef OPERAND_LATCH_CNT_EN
        checks++; if (pair_cnt !== 16'd1) begin failures++; $display("FAIL hold_cnt got=%0d exp=1", pair_cnt); end
`endif
    endtask

    task automatic test_back_to_back();
        in_valid = 1'b1; in_data = 4'h3; tick();
        in_data = 4'h6; tick();
        checks++; if (out_valid !== 1'b1 || a !== 4'h3 || b !== 4'h6) begin failures++; $display("FAIL b2b_full got ov=%b a=%h b=%h exp 1/3/6", out_valid, a, b); end
        in_data = 4'h9; out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_in_ready got=%b exp=1", in_ready); end
        tick();
        exp_cnt++;
        out_ready = 1'b0; in_valid = 1'b0;
        #1;
        checks++;
        if (a !== 4'h9 || b !== 4'h6 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL b2b_have_a got a=%h b=%h ov=%b ir=%b exp a=9 b=6 ov=0 ir=1", a, b, out_valid, in_ready);
        end
        in_valid = 1'b1; in_data = 4'h7; tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || a !== 4'h9 || b !== 4'h7) begin failures++; $display("FAIL b2b_second got ov=%b a=%h b=%h exp 1/9/7", out_valid, a, b); end
        out_ready = 1'b1; tick(); exp_cnt++;
        out_ready = 1'b0;
`ifdef OPERAND_LATCH_CNT_EN
        checks++; if (pair_cnt !== 16'(exp_cnt)) begin failures++; $display("FAIL b2b_cnt got=%0d exp=%0d", pair_cnt, exp_cnt); end
`endif
    endtask

    task automatic test_clear();
        in_valid = 1'b1; in_data = 4'h2; tick();
        clear = 1'b1; in_data = 4'h4;
        #1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL clear_in_ready got=%b exp=0", in_ready); end
        tick();
        clear = 1'b0; in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || a !== 4'h2 || b !== 4'h7) begin
            failures++;
            $display("FAIL clear_empty got ov=%b ir=%b a=%h b=%h exp 0/1/2/7", out_valid, in_ready, a, b);
        end
        in_valid = 1'b1; in_data = 4'h8; tick();
        checks++; if (a !== 4'h8 || b !== 4'h7 || out_valid !== 1'b0) begin failures++; $display("FAIL clear_reload got a=%h b=%h ov=%b exp 8/7/0", a, b, out_valid); end
        in_data = 4'h1; tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || a !== 4'h8 || b !== 4'h1) begin failures++; $display("FAIL clear_pair got ov=%b a=%h b=%h exp 1/8/1", out_valid, a, b); end
        clear = 1'b1; out_ready = 1'b1; in_valid = 1'b1; in_data = 4'hC;
        #1;
        checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin failures++; $display("FAIL clear_full_ov got ov=%b ir=%b exp ov=1 ir=0", out_valid, in_ready); end
        tick();
        exp_cnt++;
        clear = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0 || a !== 4'h8 || b !== 4'h1) begin failures++; $display("FAIL clear_full_after got ov=%b a=%h b=%h exp 0/8/1", out_valid, a, b); end
`ifdef OPERAND_LATCH_CNT_EN
        checks++; if (pair_cnt !== 16'(exp_cnt)) begin failures++; $display("FAIL clear_cnt got=%0d exp=%0d", pair_cnt, exp_cnt); end
`endif
    endtask

    task automatic test_reset_full();
        in_valid = 1'b1; in_data = 4'h3; tick();
        in_data = 4'h4; tick();
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL rstfull_pre got=%b exp=1", out_valid); end
        rst = 1'b1; out_ready = 1'b1; in_data = 4'hB;
        tick();
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        exp_cnt = 0;
        #1;
        checks++;
        if (a !== 4'h0 || b !== 4'h0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL rstfull_after got a=%h b=%h ov=%b ir=%b exp 0/0/0/1", a, b, out_valid, in_ready);
        end
`ifdef OPERAND_LATCH_CNT_EN
        checks++; if (pair_cnt !== 16'd0) begin failures++; $display("FAIL rstfull_cnt got=%0d exp=0", pair_cnt); end
`endif
    endtask

    task automatic test_random();
        int   q[$];
        logic iv;
        logic orr;
        logic [3:0] d;
        logic exp_ov;
        logic exp_ir;
        int   words_in;
        int   words_out;
        words_in = 0; words_out = 0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            iv  = 1'($urandom_range(0, 1));
            orr = 1'($urandom_range(0, 1));
            d   = 4'($urandom_range(0, 15));
            in_valid = iv; out_ready = orr; in_data = d;
            #1;
            exp_ov = (q.size() == 2);
            exp_ir = (q.size() < 2) ? 1'b1 : orr;
            checks++;
            if (out_valid !== exp_ov || in_ready !== exp_ir) begin
                failures++;
                $display("FAIL rand_hs cyc=%0d got ov=%b ir=%b exp ov=%b ir=%b", cyc, out_valid, in_ready, exp_ov, exp_ir);
            end
            if (exp_ov && orr) begin
                checks++;
                if (a !== 4'(q[0]) || b !== 4'(q[1])) begin
                    failures++;
                    $display("FAIL rand_pair cyc=%0d got a=%h b=%h exp a=%h b=%h", cyc, a, b, q[0], q[1]);
                end
                void'(q.pop_front());
                void'(q.pop_front());
                words_out += 2;
                exp_cnt++;
            end
            if (iv && exp_ir) begin
                q.push_back(int'(d));
                words_in++;
            end
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b0;
        #1;
        checks++;
        if (out_valid !== (q.size() == 2) || words_in !== words_out + q.size()) begin
            failures++;
            $display("FAIL rand_end got ov=%b exp=%b in=%0d out=%0d held=%0d", out_valid, (q.size() == 2), words_in, words_out, q.size());
        end
`ifdef OPERAND_LATCH_CNT_EN
        checks++; if (pair_cnt !== 16'(exp_cnt)) begin failures++; $display("FAIL rand_cnt got=%0d exp=%0d", pair_cnt, exp_cnt); end
`endif
    endtask

`ifdef OPERAND_LATCH_CNT_EN
    task automatic test_cnt_wrap();
        int done;
        rst = 1'b1; tick(); rst = 1'b0;
        done = 0;
        in_valid = 1'b1; out_ready = 1'b1; in_data = 4'h1;
        // Steady streaming completes one pair every two cycles after the first fill.
        for (int cyc = 0; cyc < 140000 && done < 65535; cyc++) begin
            if (cyc >= 2 && (cyc % 2) == 0) done++;
            tick();
        end
        in_valid = 1'b0;
        tick(); tick();
        checks++; if (pair_cnt !== 16'hFFFF) begin failures++; $display("FAIL wrap_preload got=%0d exp=65535", pair_cnt); end
        in_valid = 1'b1; tick(); tick();
        in_valid = 1'b0; tick();
        checks++; if (pair_cnt !== 16'h0000) begin failures++; $display("FAIL wrap_zero got=%0d exp=0", pair_cnt); end
    endtask
`endif

    initial begin
        checks = 0; failures = 0; exp_cnt = 0;
        test_reset();
        test_hold();
        test_back_to_back();
        test_clear();
        test_reset_full();
        test_random();
`ifdef OPERAND_LATCH_CNT_EN
        test_cnt_wrap();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
